sram_2p_be: RTL and testbench

- Simple dual-port synchronous SRAM: one write port and one read port, usable in the same cycle.
- Parametrised successor to the single-port core memory model, used for instruction/data memories and register-file-like buffers.
- Adds per-byte write strobes, write-first bypass on address collision, and a selectable 1- or 2-cycle read pipeline with a valid flag.
- Adds an optional post-reset clear engine that zeroes the array and reports completion.

---
 rtl/sram_2p_be.sv | 172 +++++++++++++++++
 tb/tb_sram_2p_be.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sram_2p_be.sv
// Simple dual-port synchronous SRAM with per-byte write strobes, write-first
// bypass on same-address collision, a 1- or 2-cycle read pipeline with a
// valid flag, and an optional post-reset clear engine that zeroes the array.
module sram_2p_be #(
    parameter int    WIDTH          = 32,
    parameter int    ADDR_WIDTH     = 10,
    parameter int    RD_LATENCY     = 1,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INITIAL_FILE   = ""
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_wr_en,
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic [WIDTH/8-1:0]      i_wr_be,
    input  logic                    i_rd_en,
    input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_init_done
);

    localparam int BE_WIDTH = WIDTH / 8;
    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    // Parameter legality is caught at elaboration rather than as odd behaviour.
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sram_2p_be: RD_LATENCY must be 1 or 2");
    end
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
        $error("sram_2p_be: WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    clr_we;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [WIDTH-1:0]        rd_merged;

    // Storage array; deliberately not reset.
    logic [WIDTH-1:0] mem [DEPTH];

    // Requests are only honoured once the clear engine has finished.
    assign wr_acc      = i_wr_en && (state_q == S_RUN);
    assign rd_acc      = i_rd_en && (state_q == S_RUN);
    assign o_init_done = (state_q == S_RUN);

    // Control state: FSM and clear counter.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: CLEAR sweeps every address once, then RUN forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Array update: clear engine has priority, otherwise strobed byte writes.
    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (i_wr_be[b]) begin
                    mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Write-first read word: strobed bytes of a same-address write bypass the array.
    always_comb begin
        rd_merged = mem[i_rd_addr];
        if (wr_acc && (i_wr_addr == i_rd_addr)) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (i_wr_be[b]) begin
                    rd_merged[8*b +: 8] = i_wr_data[8*b +: 8];
                end
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [WIDTH-1:0] rd_word_p0_q;
        logic             rd_vld_p0_q;
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        // First read stage: capture the merged word, no reset on data.
        always_ff @(posedge i_clk) begin
            if (rd_acc) begin
                rd_word_p0_q <= rd_merged;
            end
        end

        // First-stage valid bit; reset drops any read in flight.
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                rd_vld_p0_q <= 1'b0;
            end else begin
                rd_vld_p0_q <= rd_acc;
            end
        end

        // Output stage: present captured word, hold last value when idle.
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_vld_p0_q;
                if (rd_vld_p0_q) begin
                    rd_data_q <= rd_word_p0_q;
                end
            end
        end

        assign o_rd_data  = rd_data_q;
        assign o_rd_valid = rd_valid_q;
    end else begin : g_lat1
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        // Single read stage: present merged word the edge after the request.
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= rd_merged;
                end
            end
        end

        assign o_rd_data  = rd_data_q;
        assign o_rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sram_2p_be.sv
// Directed bench for sram_2p_be: one instance per read latency, sharing the
// same request stimulus, each with hand-computed expected outputs.
module tb_sram_2p_be;

    logic        clk;
    logic        rstn;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic [31:0] rd_data1, rd_data2;
    logic        rd_valid1, rd_valid2;
    logic        done1, done2;

    int n_cmp  = 0;
    int n_fail = 0;

    sram_2p_be #(
        .WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1), .INITIAL_FILE("")
    ) u_l1 (
        .i_clk(clk), .i_rstn(rstn),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data1), .o_rd_valid(rd_valid1), .o_init_done(done1)
    );

    sram_2p_be #(
        .WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2), .CLEAR_ON_RESET(1'b1), .INITIAL_FILE("")
    ) u_l2 (
        .i_clk(clk), .i_rstn(rstn),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data2), .o_rd_valid(rd_valid2), .o_init_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        tick();
        tick();
        n_cmp++; if (rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_l1: got %b want 0", rd_valid1); end
        n_cmp++; if (rd_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_l2: got %b want 0", rd_valid2); end
        n_cmp++; if (rd_data1 !== 32'h0) begin n_fail++; $display("FAIL reset_data_l1: got %h want 0", rd_data1); end
        n_cmp++; if (rd_data2 !== 32'h0) begin n_fail++; $display("FAIL reset_data_l2: got %h want 0", rd_data2); end
        n_cmp++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done_l1: got %b want 0", done1); end
        n_cmp++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL reset_done_l2: got %b want 0", done2); end
    endtask

    // Release reset with a read of addr 3 and a write to addr 2 held throughout.
    task automatic test_clear();
        rd_en = 1'b1; rd_addr = 4'd3;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h12345678; wr_be = 4'hF;
        rstn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_cmp++; if (rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL clear_valid_l1 edge %0d: got %b want 0", k, rd_valid1); end
            n_cmp++; if (rd_valid2 !== 1'b0) begin n_fail++; $display("FAIL clear_valid_l2 edge %0d: got %b want 0", k, rd_valid2); end
            n_cmp++; if (done1 !== (k == 16)) begin n_fail++; $display("FAIL clear_done_l1 edge %0d: got %b want %b", k, done1, (k == 16)); end
            n_cmp++; if (done2 !== (k == 16)) begin n_fail++; $display("FAIL clear_done_l2 edge %0d: got %b want %b", k, done2, (k == 16)); end
        end
        wr_en = 1'b0;
        tick();
        n_cmp++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin n_fail++; $display("FAIL clear_read3_l1: got v=%b d=%h want v=1 d=00000000", rd_valid1, rd_data1); end
        n_cmp++; if (rd_valid2 !== 1'b0) begin n_fail++; $display("FAIL clear_read3_l2_early: got v=%b want 0", rd_valid2); end
        rd_addr = 4'd2;
        tick();
        n_cmp++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin n_fail++; $display("FAIL ignore_wr_l1: got v=%b d=%h want v=1 d=00000000", rd_valid1, rd_data1); end
        n_cmp++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin n_fail++; $display("FAIL clear_read3_l2: got v=%b d=%h want v=1 d=00000000", rd_valid2, rd_data2); end
        rd_en = 1'b0;
        tick();
        n_cmp++; if (rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL clear_tail_l1: got v=%b want 0", rd_valid1); end
        n_cmp++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin n_fail++; $display("FAIL ignore_wr_l2: got v=%b d=%h want v=1 d=00000000", rd_valid2, rd_data2); end
        tick();
        n_cmp++; if (rd_valid2 !== 1'b0) begin n_fail++; $display("FAIL clear_tail_l2: got v=%b want 0", rd_valid2); end
    endtask

    task automatic test_byte_enables();
        idle();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hAABBCCDD; wr_be = 4'hF;
        tick();
        wr_data = 32'h11223344; wr_be = 4'b0101;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        n_cmp++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hAA22CC44) begin n_fail++; $display("FAIL be_l1: got v=%b d=%h want v=1 d=aa22cc44", rd_valid1, rd_data1); end
        rd_en = 1'b0;
        tick();
        n_cmp++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'hAA22CC44) begin n_fail++; $display("FAIL be_l2: got v=%b d=%h want v=1 d=aa22cc44", rd_valid2, rd_data2); end
        n_cmp++; if (rd_valid1 !== 1'b0 || rd_data1 !== 32'hAA22CC44) begin n_fail++; $display("FAIL be_hold_l1: got v=%b d=%h want v=0 d=aa22cc44", rd_valid1, rd_data1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd   [3];
        logic        v1   [5];
        logic [31:0] d1   [5];
        logic        v2   [5];
        logic [31:0] d2   [5];
        wd[0] = 32'h11110000; wd[1] = 32'h22220001; wd[2] = 32'h33330002;
        v1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        d1 = '{32'h11110000, 32'h22220001, 32'h33330002, 32'h33330002, 32'h33330002};
        v2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        d2 = '{32'hAA22CC44, 32'h11110000, 32'h22220001, 32'h33330002, 32'h33330002};
        idle();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = wd[i]; wr_be = 4'hF;
            tick();
        end
        idle();
        for (int c = 0; c < 5; c++) begin
            rd_en   = (c < 3);
            rd_addr = 4'(c);
            tick();
            n_cmp++; if (rd_valid1 !== v1[c] || rd_data1 !== d1[c]) begin n_fail++; $display("FAIL b2b_l1 cyc %0d: got v=%b d=%h want v=%b d=%h", c, rd_valid1, rd_data1, v1[c], d1[c]); end
            n_cmp++; if (rd_valid2 !== v2[c] || rd_data2 !== d2[c]) begin n_fail++; $display("FAIL b2b_l2 cyc %0d: got v=%b d=%h want v=%b d=%h", c, rd_valid2, rd_data2, v2[c], d2[c]); end
        end
    endtask

    task automatic test_collision();
        idle();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hDEADBEEF; wr_be = 4'b1100;
        rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        n_cmp++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDEAD0000) begin n_fail++; $display("FAIL coll_l1: got v=%b d=%h want v=1 d=dead0000", rd_valid1, rd_data1); end
        wr_en = 1'b0;
        tick();
        n_cmp++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDEAD0000) begin n_fail++; $display("FAIL coll_reread_l1: got v=%b d=%h want v=1 d=dead0000", rd_valid1, rd_data1); end
        n_cmp++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'hDEAD0000) begin n_fail++; $display("FAIL coll_l2: got v=%b d=%h want v=1 d=dead0000", rd_valid2, rd_data2); end
        idle();
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h5555AAAA; wr_be = 4'hF;
        tick();
        n_cmp++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'hDEAD0000) begin n_fail++; $display("FAIL coll_reread_l2: got v=%b d=%h want v=1 d=dead0000", rd_valid2, rd_data2); end
        n_cmp++; if (rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL coll_gap_l1: got v=%b want 0", rd_valid1); end
        wr_addr = 4'd8; wr_data = 32'h77777777;
        rd_en = 1'b1; rd_addr = 4'd9;
        tick();
        n_cmp++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h5555AAAA) begin n_fail++; $display("FAIL indep_l1: got v=%b d=%h want v=1 d=5555aaaa", rd_valid1, rd_data1); end
        idle();
        tick();
        n_cmp++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h5555AAAA) begin n_fail++; $display("FAIL indep_l2: got v=%b d=%h want v=1 d=5555aaaa", rd_valid2, rd_data2); end
    endtask

    task automatic test_reset_mid_read();
        idle();
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        n_cmp++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hAA22CC44) begin n_fail++; $display("FAIL pre_rst_l1: got v=%b d=%h want v=1 d=aa22cc44", rd_valid1, rd_data1); end
        rd_en = 1'b0;
        rstn = 1'b0;
        #1;
        n_cmp++; if (rd_valid2 !== 1'b0 || rd_data2 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_l2: got v=%b d=%h want v=0 d=00000000", rd_valid2, rd_data2); end
        n_cmp++; if (rd_valid1 !== 1'b0 || rd_data1 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_l1: got v=%b d=%h want v=0 d=00000000", rd_valid1, rd_data1); end
        n_cmp++; if (done1 !== 1'b0 || done2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b%b want 00", done1, done2); end
        tick();
        rstn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_cmp++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid edge %0d: got %b%b want 00", k, rd_valid1, rd_valid2); end
        end
        n_cmp++; if (done1 !== 1'b1 || done2 !== 1'b1) begin n_fail++; $display("FAIL post_rst_done: got %b%b want 11", done1, done2); end
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        n_cmp++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin n_fail++; $display("FAIL reclear_l1: got v=%b d=%h want v=1 d=00000000", rd_valid1, rd_data1); end
        rd_en = 1'b0;
        tick();
        n_cmp++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin n_fail++; $display("FAIL reclear_l2: got v=%b d=%h want v=1 d=00000000", rd_valid2, rd_data2); end
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        test_reset();
        test_clear();
        test_byte_enables();
        test_back_to_back();
        test_collision();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
